// File: rtl/rgb888_to_rgb444_ditherer.sv
// RGB888 -> RGB444 stream converter with optional 4x4 ordered dither.
// Two register stages: S1 holds c8*15 per channel plus the dither value, S2 drives m_*.
module rgb888_to_rgb444_ditherer #(
  parameter bit DITHER_DEFAULT = 1'b1,
  parameter int PIX_CNT_W      = 22
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dither_en,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [23:0]          s_data,
  input  logic                 s_sof,
  input  logic                 s_eol,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [11:0]          m_data,
  output logic                 m_sof,
  output logic                 m_eol,
  output logic [PIX_CNT_W-1:0] pix_count
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high. The producer holds its payload stable while valid && !ready.

  // DITHER_DEFAULT only documents the expected power-up setting of dither_en.
  if (DITHER_DEFAULT) begin : g_dither_default_on
  end

  localparam logic [PIX_CNT_W-1:0] PIX_ONE = PIX_CNT_W'(1);

  logic [1:0]           x_phase_q, x_phase_d;
  logic [1:0]           y_phase_q, y_phase_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [11:0]          s1_r_q, s1_r_d;
  logic [11:0]          s1_g_q, s1_g_d;
  logic [11:0]          s1_b_q, s1_b_d;
  logic [3:0]           s1_dith_q, s1_dith_d;
  logic                 s1_sof_q, s1_sof_d;
  logic                 s1_eol_q, s1_eol_d;
  logic                 m_valid_q, m_valid_d;
  logic [11:0]          m_data_q, m_data_d;
  logic                 m_sof_q, m_sof_d;
  logic                 m_eol_q, m_eol_d;
  logic [PIX_CNT_W-1:0] pix_count_q, pix_count_d;

  logic       s2_load;
  logic       s_xfer;
  logic       m_xfer;
  logic [1:0] cur_x;
  logic [1:0] cur_y;

  function automatic logic [3:0] bayer(input logic [1:0] y, input logic [1:0] x);
    case ({y, x})
      4'h0:    bayer = 4'd0;
      4'h1:    bayer = 4'd8;
      4'h2:    bayer = 4'd2;
      4'h3:    bayer = 4'd10;
      4'h4:    bayer = 4'd12;
      4'h5:    bayer = 4'd4;
      4'h6:    bayer = 4'd14;
      4'h7:    bayer = 4'd6;
      4'h8:    bayer = 4'd3;
      4'h9:    bayer = 4'd11;
      4'ha:    bayer = 4'd1;
      4'hb:    bayer = 4'd9;
      4'hc:    bayer = 4'd15;
      4'hd:    bayer = 4'd7;
      4'he:    bayer = 4'd13;
      default: bayer = 4'd5;
    endcase
  endfunction

  // c*15 as c*16 - c; the largest intermediate (4080) still fits in 12 bits.
  function automatic logic [11:0] times15(input logic [7:0] c);
    times15 = ({4'b0000, c} << 4) - {4'b0000, c};
  endfunction

  // Sum peaks at 3825 + 240 + 8 = 4073, so bits [11:8] never overflow 15.
  function automatic logic [3:0] quant(input logic [11:0] p, input logic [3:0] d);
    logic [11:0] sum;
    sum   = p + {4'b0000, d, 4'b0000} + 12'd8;
    quant = sum[11:8];
  endfunction

  assign s2_load = !m_valid_q || m_ready;
  assign s_ready = !s1_valid_q || s2_load;
  assign s_xfer  = s_valid && s_ready;
  assign m_xfer  = m_valid_q && m_ready;

  // A pixel carrying sof always sits at phase (0,0), even mid-line.
  assign cur_x = s_sof ? 2'd0 : x_phase_q;
  assign cur_y = s_sof ? 2'd0 : y_phase_q;

  always_comb begin
    x_phase_d  = x_phase_q;
    y_phase_d  = y_phase_q;
    s1_valid_d = s1_valid_q;
    s1_r_d     = s1_r_q;
    s1_g_d     = s1_g_q;
    s1_b_d     = s1_b_q;
    s1_dith_d  = s1_dith_q;
    s1_sof_d   = s1_sof_q;
    s1_eol_d   = s1_eol_q;
    if (s_ready) begin
      s1_valid_d = s_valid;
    end
    if (s_xfer) begin
      x_phase_d = s_eol ? 2'd0 : cur_x + 2'd1;
      y_phase_d = s_eol ? cur_y + 2'd1 : cur_y;
      s1_r_d    = times15(s_data[23:16]);
      s1_b_d    = times15(s_data[15:8]);
      s1_g_d    = times15(s_data[7:0]);
      s1_dith_d = dither_en ? bayer(cur_y, cur_x) : 4'd8;
      s1_sof_d  = s_sof;
      s1_eol_d  = s_eol;
    end
  end

  always_comb begin
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_sof_d     = m_sof_q;
    m_eol_d     = m_eol_q;
    pix_count_d = pix_count_q;
    if (s2_load) begin
      m_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        m_data_d = {quant(s1_r_q, s1_dith_q), quant(s1_g_q, s1_dith_q),
                    quant(s1_b_q, s1_dith_q)};
        m_sof_d  = s1_sof_q;
        m_eol_d  = s1_eol_q;
      end
    end
    if (m_xfer) begin
      if (m_sof_q) begin
        pix_count_d = PIX_ONE;
      end else if (!(&pix_count_q)) begin
        pix_count_d = pix_count_q + PIX_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_phase_q   <= 2'd0;
      y_phase_q   <= 2'd0;
      s1_valid_q  <= 1'b0;
      s1_r_q      <= 12'd0;
      s1_g_q      <= 12'd0;
      s1_b_q      <= 12'd0;
      s1_dith_q   <= 4'd0;
      s1_sof_q    <= 1'b0;
      s1_eol_q    <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= 12'd0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      pix_count_q <= '0;
    end else begin
      x_phase_q   <= x_phase_d;
      y_phase_q   <= y_phase_d;
      s1_valid_q  <= s1_valid_d;
      s1_r_q      <= s1_r_d;
      s1_g_q      <= s1_g_d;
      s1_b_q      <= s1_b_d;
      s1_dith_q   <= s1_dith_d;
      s1_sof_q    <= s1_sof_d;
      s1_eol_q    <= s1_eol_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_sof_q     <= m_sof_d;
      m_eol_q     <= m_eol_d;
      pix_count_q <= pix_count_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sof     = m_sof_q;
  assign m_eol     = m_eol_q;
  assign pix_count = pix_count_q;

endmodule

// File: tb/tb_rgb888_to_rgb444_ditherer.sv
// Bench for rgb888_to_rgb444_ditherer: directed vector table plus hand-written
// latency, backpressure and mid-stream reset sequences.
module tb_rgb888_to_rgb444_ditherer;

  localparam int PCW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           dither_en;
  logic           s_valid;
  logic           s_ready;
  logic [23:0]    s_data;
  logic           s_sof;
  logic           s_eol;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [11:0]    m_data;
  logic           m_sof;
  logic           m_eol;
  logic [PCW-1:0] pix_count;

  typedef struct {
    logic [23:0] data;
    logic        de;
    logic        sof;
    logic        eol;
    logic [11:0] exp;
  } vec_t;

  vec_t        vecs[$];
  vec_t        bpv[$];
  logic [13:0] exp_q[$];
  logic [13:0] mon_e;
  logic [PCW-1:0] pc_model;
  logic        hold_pending;
  logic [13:0] held;
  logic        saw_sready_low;
  int          rdy_mode;
  int          bp_cnt;
  int          n_tests = 0;
  int          n_fail  = 0;

  rgb888_to_rgb444_ditherer #(
    .DITHER_DEFAULT(1'b1),
    .PIX_CNT_W     (PCW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dither_en(dither_en),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .s_eol    (s_eol),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sof    (m_sof),
    .m_eol    (m_eol),
    .pix_count(pix_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // Called at posedge+2; returns at posedge+2 just after the transfer edge.
  task automatic send(input logic [23:0] d, input logic de, input logic sof, input logic eol);
    int guard;
    guard     = 0;
    s_valid   = 1'b1;
    s_data    = d;
    dither_en = de;
    s_sof     = sof;
    s_eol     = eol;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!s_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout s_ready=%0b required=1", s_ready);
    end
    @(posedge clk);
    #2;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    @(posedge clk);
    #2;
  endtask

  // ---------------- m_ready driver ----------------
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: begin
        if (bp_cnt < 4) m_ready = 1'b0;
        else if (bp_cnt < 12) m_ready = bp_cnt[0];
        else m_ready = 1'($urandom_range(0, 1));
        bp_cnt++;
      end
      default: m_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("pix_count", 32'(pix_count), 32'(pc_model));
      if (hold_pending) begin
        check("hold_stable", {17'd0, m_valid, m_sof, m_eol, m_data}, {17'd0, 1'b1, held});
      end
      if (!s_ready) begin
        saw_sready_low = 1'b1;
        check("sready_low_cause", {30'd0, m_valid, m_ready}, 32'd2);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out got=%h required=none", {m_sof, m_eol, m_data});
        end else begin
          mon_e = exp_q.pop_front();
          check("out_pixel", {18'd0, m_sof, m_eol, m_data}, {18'd0, mon_e});
          if (m_sof) pc_model = PCW'(1);
          else if (pc_model != {PCW{1'b1}}) pc_model = pc_model + PCW'(1);
        end
      end
      hold_pending = m_valid && !m_ready;
      held         = {m_sof, m_eol, m_data};
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n          = 1'b0;
    s_valid        = 1'b0;
    s_data         = 24'd0;
    s_sof          = 1'b0;
    s_eol          = 1'b0;
    dither_en      = 1'b0;
    rdy_mode       = 0;
    bp_cnt         = 0;
    pc_model       = '0;
    hold_pending   = 1'b0;
    held           = 14'd0;
    saw_sready_low = 1'b0;

    // Dither off: c8 = 17k maps exactly to k on every channel.
    for (int k = 0; k < 16; k++) begin
      vecs.push_back('{{3{8'(17 * k)}}, 1'b0, (k == 0), (k == 15), 12'(k * 273)});
    end
    // Dither on, two lines of mid grey: rows 0 and 1 of the matrix.
    vecs.push_back('{24'h808080, 1'b1, 1'b1, 1'b0, 12'h777});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b0, 12'h777});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b1, 12'h888});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b0, 12'h777});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h808080, 1'b1, 1'b0, 1'b1, 12'h777});
    // Row 2 line with sof on its 3rd pixel: d=3, 11, then 0 (reset), then 8.
    vecs.push_back('{24'h878787, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h878787, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h878787, 1'b1, 1'b1, 1'b0, 12'h777});
    vecs.push_back('{24'h878787, 1'b1, 1'b0, 1'b1, 12'h888});
    // One-pixel line (sof+eol), then row 1: d=12, then dither off at x=1 (d=8, not 4).
    vecs.push_back('{24'h878787, 1'b1, 1'b1, 1'b1, 12'h777});
    vecs.push_back('{24'h878787, 1'b1, 1'b0, 1'b0, 12'h888});
    vecs.push_back('{24'h808080, 1'b0, 1'b0, 1'b0, 12'h888});

    bpv.push_back('{24'h110022, 1'b0, 1'b0, 1'b0, 12'h120});
    bpv.push_back('{24'h334455, 1'b0, 1'b0, 1'b0, 12'h354});
    bpv.push_back('{24'hFF00EE, 1'b0, 1'b0, 1'b0, 12'hFE0});
    bpv.push_back('{24'h778899, 1'b0, 1'b0, 1'b0, 12'h798});
    bpv.push_back('{24'hAABBCC, 1'b0, 1'b0, 1'b0, 12'hACB});
    bpv.push_back('{24'hDDEE11, 1'b0, 1'b0, 1'b0, 12'hD1E});
    bpv.push_back('{24'h00FF00, 1'b0, 1'b0, 1'b0, 12'h00F});
    bpv.push_back('{24'h226644, 1'b0, 1'b0, 1'b0, 12'h246});

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("rst_m_valid_in_reset", 32'(m_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_sof", 32'(m_sof), 32'd0);
    check("rst_m_eol", 32'(m_eol), 32'd0);
    check("rst_pix_count", 32'(pix_count), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    #2;

    // Latency: m_valid appears on the second edge counting the acceptance edge.
    exp_q.push_back({1'b1, 1'b0, 12'hF80});
    send(24'hFF0088, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("lat_after_accept_edge", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_after_second_edge", 32'(m_valid), 32'd1);
    @(posedge clk);
    #2;

    // Vector table, full throughput.
    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].sof, vecs[i].eol, vecs[i].exp});
      send(vecs[i].data, vecs[i].de, vecs[i].sof, vecs[i].eol);
    end
    drain();

    // Backpressure.
    bp_cnt         = 0;
    saw_sready_low = 1'b0;
    rdy_mode       = 1;
    foreach (bpv[i]) begin
      exp_q.push_back({bpv[i].sof, bpv[i].eol, bpv[i].exp});
      send(bpv[i].data, bpv[i].de, bpv[i].sof, bpv[i].eol);
    end
    drain();
    rdy_mode = 0;
    check("sready_low_seen", 32'(saw_sready_low), 32'd1);

    // Asynchronous reset with two pixels in flight.
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #2;
    send(24'h123456, 1'b1, 1'b0, 1'b0);
    send(24'h654321, 1'b1, 1'b0, 1'b0);
    #1;
    check("pre_reset_m_valid", 32'(m_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_m_valid", 32'(m_valid), 32'd0);
    check("async_rst_pix_count", 32'(pix_count), 32'd0);
    check("async_rst_s_ready", 32'(s_ready), 32'd1);
    exp_q.delete();
    pc_model     = '0;
    hold_pending = 1'b0;
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (3) @(posedge clk);
    #2;
    // No sof: phase must be (0,0) after reset, so d=0 gives 7 rather than 8.
    exp_q.push_back({1'b0, 1'b0, 12'h777});
    send(24'h878787, 1'b1, 1'b0, 1'b0);
    drain();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb888_to_rgb444_ditherer.md
Name: rgb888_to_rgb444_ditherer

Overview:
- Streaming pixel down-converter: accepts RGB888 pixels on a valid/ready stream and emits RGB444 pixels on a valid/ready stream.
- Optional 4x4 ordered (Bayer) dither hides banding.
- Sits between the capture/render path (24-bit) and the 12-bit frame buffer write port, i.e. opposite the display-side 444->888 expander.
- Channel order on both sides is fixed: input s_data = {R[23:16], B[15:8], G[7:0]}, output m_data = {R[11:8], G[7:4], B[3:0]}.

Parameters:
DITHER_DEFAULT, 1, value dither_en takes effect as from reset (documentation only; runtime input governs)
PIX_CNT_W, 22, width of frame pixel counter

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
dither_en  input  1  1 = Bayer dither, 0 = plain rounding; sampled per accepted pixel
s_valid  input  1  input pixel valid
s_ready  output  1  converter can accept a pixel this cycle
s_data  input  24  {R8,B8,G8}
s_sof  input  1  marks first pixel of frame
s_eol  input  1  marks last pixel of a line
m_valid  output  1  output pixel valid
m_ready  input  1  downstream accepts
m_data  output  12  {R4,G4,B4}
m_sof  output  1  sof aligned with m_data
m_eol  output  1  eol aligned with m_data
pix_count  output  PIX_CNT_W  pixels output since last sof (inclusive), saturating

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, pix_count=0, x_phase=0, y_phase=0, both pipeline valid bits 0.
- s_ready=1 after reset.
- Transfers: a transfer occurs on a clock edge where valid&&ready.
  - Output holds m_data/m_sof/m_eol stable while m_valid && !m_ready.
  - No combinational path from s_valid to m_valid.
- Pipeline: two stages, S1 and S2; S2 drives the m_* registers.
  - S1 registers the per-channel products c8*15 (12 bits) plus the dither offset.
  - S2 registers the add/shift result.
  - Latency: 2 cycles from input transfer to m_valid with no backpressure.
  - Throughput: 1 pixel/clk.
- Stall rule:
  - S2 loads when !S2.valid || m_ready.
  - S1 advances when S2 loads.
  - s_ready = !S1.valid || S2 loads (registered or combinational from m_ready allowed; no pixel may be dropped or duplicated).
- Dither phase, updated on each input transfer:
  - Pixel with s_sof uses x=0, y=0.
  - Next x = (s_eol ? 0 : x+1) mod 4.
  - Next y = s_eol ? y+1 mod 4 : y; on sof, next y = s_eol ? 1 : 0.
  - s_sof mid-line overrides all phase state.
- Dither value d = B[y][x], with rows:
  - row 0: 0 8 2 10
  - row 1: 12 4 14 6
  - row 2: 3 11 1 9
  - row 3: 15 7 13 5
  - When dither_en=0 (captured with the pixel), d=8.
- Arithmetic, per channel: c4 = (c8*15 + d*16 + 8) >> 8.
  - Max intermediate is 4073 (12 bits); the result is always <= 15, so no saturation is needed.
  - With dither off, c8 = 17k round-trips to k exactly.
- pix_count:
  - Set to 1 on output transfer carrying m_sof.
  - Otherwise incremented on each output transfer.
  - Holds at all-ones.
- Simultaneous s_sof and s_eol on one pixel is legal (one-pixel line): it is emitted with both flags.
- Reset mid-operation flushes in-flight pixels; no output follows until new input.

Test Plan:
- Dither off, one pixel s_data=0xFF0088 (R=FF,B=00,G=88), m_ready=1 -> m_data=0xF80 exactly 2 cycles after acceptance, m_sof follows s_sof.
- Dither off, sweep c8=0x00,0x11..0xFF on all channels -> outputs 0x000,0x111..0xFFF (round-trip exact).
- Dither on, sof then 4 pixels of 0x808080, last with eol -> 0x777,0x888,0x777,0x888. Then the next line uses row 1 (d=12,4,14,6) -> 0x888,0x777,0x888,0x777.
- Backpressure: stream 8 pixels with m_ready toggling 1010... and randomly holding -> all 8 out in order, none lost or duplicated, m_data stable while stalled, s_ready low when both stages full.
- s_sof asserted on 3rd pixel of a line -> that pixel uses d=0 (dither phase reset). pix_count reads 1 on its output transfer, 2 on the next.
- Assert rst_n=0 asynchronously with 2 pixels in flight -> m_valid drops immediately, pix_count=0. After release, the first pixel (without sof) uses phase (0,0).
